// File: rtl/symbol_rom_arbiter.sv
// Round-robin arbiter sharing one registered symbol ROM between two requesters.
// Each read takes four clocks: grant/address, ROM latency, capture, acknowledge.
module symbol_rom_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              ack0,
  output logic              ack1,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    CAPT = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   grant_any;
  logic   grant_id;
  logic   last_grant;
  logic   gnt_id;

  // Next-state and grant selection; on a tie the requester not served last wins.
  always_comb begin
    state_nxt = state;
    grant_any = 1'b0;
    grant_id  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          grant_any = 1'b1;
          grant_id  = ~last_grant;
        end else if (req0) begin
          grant_any = 1'b1;
          grant_id  = 1'b0;
        end else if (req1) begin
          grant_any = 1'b1;
          grant_id  = 1'b1;
        end else begin
          grant_any = 1'b0;
          grant_id  = 1'b0;
        end
        if (grant_any) begin
          state_nxt = ADDR;
        end else begin
          state_nxt = IDLE;
        end
      end
      ADDR:    state_nxt = WAIT;
      WAIT:    state_nxt = CAPT;
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: address latched only at grant, data captured while ROM output is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr   <= {ADDR_W{1'b0}};
      data_out   <= {DATA_W{1'b0}};
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
    end else begin
      if (state == IDLE && grant_any) begin
        rom_addr   <= grant_id ? addr1 : addr0;
        gnt_id     <= grant_id;
        last_grant <= grant_id;
      end
      if (state == WAIT) begin
        data_out <= rom_q;
      end
      ack0 <= (state == WAIT) && !gnt_id;
      ack1 <= (state == WAIT) && gnt_id;
      busy <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_symbol_rom_arbiter.sv
// Directed self-checking bench for symbol_rom_arbiter with a one-register ROM model.
module tb_symbol_rom_arbiter;

  logic       clk;
  logic       rst;
  logic       req0;
  logic [1:0] addr0;
  logic       req1;
  logic [1:0] addr1;
  logic [6:0] rom_q;
  logic [1:0] rom_addr;
  logic [6:0] data_out;
  logic       ack0;
  logic       ack1;
  logic       busy;

  int checks;
  int failures;

  logic [6:0] rom_tbl [4];

  symbol_rom_arbiter #(.ADDR_W(2), .DATA_W(7)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0),
    .req1(req1), .addr1(addr1),
    .rom_q(rom_q), .rom_addr(rom_addr),
    .data_out(data_out), .ack0(ack0), .ack1(ack1), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Symbol ROM: address registered, data valid the cycle after.
  always @(posedge clk) rom_q <= rom_tbl[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = 2'd0; addr1 = 2'd0;
    tick(); tick();
    checks++;
    if (rom_addr !== 2'd0 || data_out !== 7'd0 || ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: rom_addr=%0d data_out=%h ack0=%b ack1=%b busy=%b, want all 0",
               rom_addr, data_out, ack0, ack1, busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || ack0 !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: busy=%b ack0=%b want 0 0", busy, ack0);
    end
  endtask

  task automatic test_single_read();
    req0 = 1'b1; addr0 = 2'd2;
    tick();
    checks++;
    if (rom_addr !== 2'd2 || busy !== 1'b1 || ack0 !== 1'b0) begin
      failures++;
      $display("FAIL single_e1: rom_addr=%0d busy=%b ack0=%b want 2 1 0", rom_addr, busy, ack0);
    end
    tick();
    checks++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_e2: ack0=%b ack1=%b busy=%b want 0 0 1", ack0, ack1, busy);
    end
    tick();
    checks++;
    if (data_out !== 7'h5B || ack0 !== 1'b1 || ack1 !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_e3: data_out=%h ack0=%b ack1=%b busy=%b want 5b 1 0 1",
               data_out, ack0, ack1, busy);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (ack0 !== 1'b0 || busy !== 1'b0 || data_out !== 7'h5B || rom_addr !== 2'd2) begin
      failures++;
      $display("FAIL single_e4: ack0=%b busy=%b data_out=%h rom_addr=%0d want 0 0 5b 2",
               ack0, busy, data_out, rom_addr);
    end
  endtask

  task automatic test_simultaneous();
    int c0;
    int c1;
    logic [6:0] d0;
    logic [6:0] d1;
    int both;
    c0 = -1; c1 = -1; d0 = 7'd0; d1 = 7'd0; both = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 2'd1; addr1 = 2'd3;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (ack0 && ack1) both++;
      if (ack0 && c0 < 0) begin c0 = c; d0 = data_out; req0 = 1'b0; end
      if (ack1 && c1 < 0) begin c1 = c; d1 = data_out; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (c0 != 3 || d0 !== 7'h06) begin
      failures++;
      $display("FAIL tie_first: ack0 cycle=%0d data=%h want 3 06", c0, d0);
    end
    checks++;
    if (c1 != 7 || d1 !== 7'h4F) begin
      failures++;
      $display("FAIL tie_second: ack1 cycle=%0d data=%h want 7 4f", c1, d1);
    end
    checks++;
    if (both != 0) begin
      failures++;
      $display("FAIL tie_exclusive: both-ack cycles=%0d want 0", both);
    end
  endtask

  task automatic test_contention();
    int n;
    int seq [4];
    int cyc [4];
    int bad_data;
    n = 0; bad_data = 0;
    for (int i = 0; i < 4; i++) begin seq[i] = -1; cyc[i] = -1; end
    req0 = 1'b1; req1 = 1'b1; addr0 = 2'd2; addr1 = 2'd0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (ack0 || ack1) begin
        if (n < 4) begin seq[n] = ack1 ? 1 : 0; cyc[n] = c; end
        if (ack0 && data_out !== 7'h5B) bad_data++;
        if (ack1 && data_out !== 7'h3F) bad_data++;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    checks++;
    if (n != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 0 || seq[3] != 1) begin
      failures++;
      $display("FAIL contention_order: n=%0d seq=%0d,%0d,%0d,%0d want 4 acks 0,1,0,1",
               n, seq[0], seq[1], seq[2], seq[3]);
    end
    checks++;
    if (cyc[0] != 3 || cyc[1] != 7 || cyc[2] != 11 || cyc[3] != 15) begin
      failures++;
      $display("FAIL contention_timing: cycles=%0d,%0d,%0d,%0d want 3,7,11,15",
               cyc[0], cyc[1], cyc[2], cyc[3]);
    end
    checks++;
    if (bad_data != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL contention_data: bad=%0d busy=%b want 0 0", bad_data, busy);
    end
  endtask

  task automatic test_addr_change_drop();
    req1 = 1'b1; addr1 = 2'd0;
    tick();
    checks++;
    if (rom_addr !== 2'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL drop_grant: rom_addr=%0d busy=%b want 0 1", rom_addr, busy);
    end
    addr1 = 2'd3; req1 = 1'b0;
    tick(); tick();
    checks++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0 || data_out !== 7'h3F || rom_addr !== 2'd0) begin
      failures++;
      $display("FAIL drop_ack: ack1=%b ack0=%b data_out=%h rom_addr=%0d want 1 0 3f 0",
               ack1, ack0, data_out, rom_addr);
    end
    tick();
    checks++;
    if (ack1 !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_end: ack1=%b busy=%b want 0 0", ack1, busy);
    end
  endtask

  task automatic test_reset_mid_read();
    req0 = 1'b1; addr0 = 2'd3;
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (ack0 !== 1'b0 || data_out !== 7'd0 || busy !== 1'b0 || rom_addr !== 2'd0) begin
      failures++;
      $display("FAIL midreset: ack0=%b data_out=%h busy=%b rom_addr=%0d want 0 00 0 0",
               ack0, data_out, busy, rom_addr);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (ack0 !== 1'b0 || data_out !== 7'd0) begin
      failures++;
      $display("FAIL midreset_hold: ack0=%b data_out=%h want 0 00", ack0, data_out);
    end
    tick();
    checks++;
    if (rom_addr !== 2'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reserve_e1: rom_addr=%0d busy=%b want 3 1", rom_addr, busy);
    end
    tick(); tick();
    checks++;
    if (ack0 !== 1'b1 || data_out !== 7'h4F) begin
      failures++;
      $display("FAIL reserve_e3: ack0=%b data_out=%h want 1 4f", ack0, data_out);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (ack0 !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reserve_e4: ack0=%b busy=%b want 0 0", ack0, busy);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rom_tbl[0] = 7'h3F; rom_tbl[1] = 7'h06; rom_tbl[2] = 7'h5B; rom_tbl[3] = 7'h4F;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_contention();
    test_addr_change_drop();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
